awg_pwm_dac: RTL and testbench

- Output stage directly downstream of the waveform generator.
- Converts the generator's 10-bit sample stream into a single-bit DAC drive for an external RC filter.
- Drive is selectable as PWM or first-order sigma-delta (PDM).
- Double-buffers samples so a sample only takes effect at a frame boundary, and flags samples that are lost.

---
 rtl/awg_pwm_dac.sv | 114 +++++++++++
 tb/tb_awg_pwm_dac.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/awg_pwm_dac.sv
// Single-bit DAC drive for the waveform generator output: PWM or first-order
// sigma-delta, with a double-buffered sample that only takes effect at frame boundaries.
module awg_pwm_dac #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mode,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic             clr_overrun,
  output logic             sample_ready,
  output logic             dac_out,
  output logic             frame_start,
  output logic             overrun
);

  typedef enum logic {
    MODE_PWM = 1'b0,
    MODE_PDM = 1'b1
  } mode_e;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pending;
  logic             pending_full;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] acc;
  mode_e            mode_q;
  mode_e            mode_in;

  logic             frame_end;
  logic             load;
  logic             consume;
  logic             overrun_set;
  logic [WIDTH:0]   pdm_sum;
  logic             mod_bit;

  assign mode_in     = mode_e'(mode);
  assign frame_end   = (cnt == '1);
  // While idle every cycle is a load, so active keeps tracking the newest sample.
  assign load        = ~enable | frame_end;
  assign consume     = load & pending_full;
  assign overrun_set = sample_valid & pending_full & ~load;
  assign pdm_sum     = {1'b0, acc} + {1'b0, active};
  assign mod_bit     = (mode_q == MODE_PDM) ? pdm_sum[WIDTH] : (cnt < active);

  assign sample_ready = ~pending_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // A capture coinciding with a consume hands the old pending to active and
  // keeps the buffer full with the new sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending      <= '0;
      pending_full <= 1'b0;
      active       <= '0;
      mode_q       <= MODE_PWM;
    end else begin
      if (sample_valid) begin
        pending      <= sample_in;
        pending_full <= 1'b1;
      end else if (consume) begin
        pending_full <= 1'b0;
      end
      if (consume) begin
        active <= pending;
      end
      if (load) begin
        mode_q <= mode_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (!enable || (load && (mode_in != mode_q))) begin
      acc <= '0;
    end else if (mode_q == MODE_PDM) begin
      acc <= pdm_sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (overrun_set) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_out     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      dac_out     <= enable & mod_bit;
      frame_start <= enable & (cnt == '0);
    end
  end

endmodule

// File: tb/tb_awg_pwm_dac.sv
// Directed bench for awg_pwm_dac: stimulus queues per-frame expectations,
// a monitor measures each frame between frame_start pulses and scores it.
module tb_awg_pwm_dac;

  localparam int unsigned WIDTH = 10;
  localparam int FRAME = 1024;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             mode;
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic             clr_overrun;
  logic             sample_ready;
  logic             dac_out;
  logic             frame_start;
  logic             overrun;

  awg_pwm_dac #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mode         (mode),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .clr_overrun  (clr_overrun),
    .sample_ready (sample_ready),
    .dac_out      (dac_out),
    .frame_start  (frame_start),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    ones;
    int    lead;
    int    trans;
  } frame_exp_t;

  frame_exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int pos = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input string nm, input int ones, input int lead, input int trans);
    frame_exp_t e;
    e.nm = nm; e.ones = ones; e.lead = lead; e.trans = trans;
    sb.push_back(e);
  endtask

  // Monitor: a frame runs from one frame_start to the next.
  bit in_frame = 1'b0;
  bit lead_open;
  bit prev_bit;
  int f_len, f_ones, f_lead, f_trans;

  initial begin : monitor
    frame_exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
      end else begin
        if (frame_start) begin
          if (in_frame && sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.nm, ".len"},   f_len,   FRAME);
            chk({e.nm, ".ones"},  f_ones,  e.ones);
            chk({e.nm, ".lead"},  f_lead,  e.lead);
            chk({e.nm, ".trans"}, f_trans, e.trans);
          end
          in_frame = 1'b1;
          f_len = 0; f_ones = 0; f_lead = 0; f_trans = 0; lead_open = 1'b1;
        end
        if (in_frame) begin
          if (f_len > 0 && dac_out != prev_bit) f_trans++;
          f_len++;
          if (dac_out) f_ones++;
          if (lead_open && dac_out) f_lead++;
          else lead_open = 1'b0;
          prev_bit = dac_out;
        end
      end
    end
  end

  // pos tracks the DUT counter value of the current cycle.
  task automatic wait_frame(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < FRAME + 50);
    #1;
    pos = 1;
    chk({nm, ".frame_start_seen"}, int'(frame_start), 1);
  endtask

  task automatic goto_cnt(input int c);
    while (pos < c) begin
      @(negedge clk);
      #1;
      pos++;
    end
  endtask

  task automatic send(input int v, input bit clr);
    sample_in    = WIDTH'(v);
    sample_valid = 1'b1;
    clr_overrun  = clr;
    @(negedge clk);
    #1;
    sample_valid = 1'b0;
    clr_overrun  = 1'b0;
    pos++;
  endtask

  task automatic pulse_clr();
    clr_overrun = 1'b1;
    @(negedge clk);
    #1;
    clr_overrun = 1'b0;
    pos++;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1; enable = 1'b0; mode = 1'b0;
    sample_in = '0; sample_valid = 1'b0; clr_overrun = 1'b0;
    #23;
    chk("rst.dac_out", int'(dac_out), 0);
    chk("rst.frame_start", int'(frame_start), 0);
    chk("rst.overrun", int'(overrun), 0);
    chk("rst.sample_ready", int'(sample_ready), 1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;

    // Idle: sample passes straight through pending into active.
    send(256, 1'b0);
    chk("idle.ready_after_capture", int'(sample_ready), 0);
    @(negedge clk);
    #1;
    chk("idle.ready_after_load", int'(sample_ready), 1);
    chk("idle.dac_out", int'(dac_out), 0);

    enable = 1'b1;
    @(negedge clk);
    #1;
    pos = 1;
    chk("enable.first_frame_start", int'(frame_start), 1);
    push_exp("pwm256", 256, 256, 1);
    goto_cnt(50);
    send(0, 1'b0);

    wait_frame("B");
    push_exp("pwm0", 0, 0, 0);
    goto_cnt(100);
    send(1023, 1'b0);
    chk("B.ready_buffered", int'(sample_ready), 0);

    wait_frame("C");
    push_exp("pwm1023", 1023, 1023, 1);
    chk("C.ready", int'(sample_ready), 1);
    chk("C.overrun_clear", int'(overrun), 0);
    goto_cnt(200);
    send(10, 1'b0);
    chk("C.no_overrun_first", int'(overrun), 0);
    goto_cnt(300);
    send(20, 1'b0);
    chk("C.overrun_set", int'(overrun), 1);

    wait_frame("D");
    push_exp("pwm20", 20, 20, 1);
    goto_cnt(50);
    pulse_clr();
    chk("D.clr_overrun", int'(overrun), 0);
    goto_cnt(100);
    send(30, 1'b0);
    goto_cnt(1023);
    send(40, 1'b0);
    chk("D.simul_overrun", int'(overrun), 0);
    chk("D.simul_ready", int'(sample_ready), 0);

    wait_frame("E");
    push_exp("pwm30", 30, 30, 1);
    goto_cnt(100);
    send(50, 1'b1);
    chk("E.set_beats_clear", int'(overrun), 1);

    wait_frame("F");
    push_exp("pwm50_then_switch", 50, 50, 1);
    goto_cnt(50);
    pulse_clr();
    chk("F.clr_overrun", int'(overrun), 0);
    goto_cnt(500);
    mode = 1'b1;
    goto_cnt(600);
    send(512, 1'b0);

    wait_frame("G");
    push_exp("pdm512", 512, 0, 1023);
    goto_cnt(100);
    send(1, 1'b0);

    wait_frame("H");
    push_exp("pdm1", 1, 0, 1);
    goto_cnt(100);
    send(900, 1'b0);
    goto_cnt(200);
    send(901, 1'b0);
    chk("H.overrun_set", int'(overrun), 1);
    goto_cnt(500);
    mode = 1'b0;

    // Frame I (PWM 901) is cut short by reset, so it carries no expectation.
    wait_frame("I");
    goto_cnt(5);
    send(777, 1'b0);
    goto_cnt(10);
    chk("I.dac_out_high", int'(dac_out), 1);
    chk("I.overrun_high", int'(overrun), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.dac_out", int'(dac_out), 0);
    chk("midrst.frame_start", int'(frame_start), 0);
    chk("midrst.overrun", int'(overrun), 0);
    chk("midrst.sample_ready", int'(sample_ready), 1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    pos = 1;
    chk("postrst.first_frame_start", int'(frame_start), 1);
    push_exp("postrst_pwm0", 0, 0, 0);

    wait_frame("K");
    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
